// File: rtl/sad_min_tracker.sv
// Per-partition running-minimum SAD tracker over a search window of NUM_CAND candidates.
// Every lane keeps its own best SAD and the MV that produced it; done pulses when the window completes.
module sad_min_tracker #(
  parameter int NUM_PART  = 32,
  parameter int SAD_W     = 13,
  parameter int MV_W      = 12,
  parameter int NUM_CAND  = 64,
  parameter int TIE_FIRST = 1,
  localparam int CNT_W    = $clog2(NUM_CAND + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       in_valid,
  input  logic [NUM_PART*SAD_W-1:0]  sad_in,
  input  logic [MV_W-1:0]            mv_in,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_W-1:0]           cand_cnt,
  output logic [NUM_PART*SAD_W-1:0]  min_sad,
  output logic [NUM_PART*MV_W-1:0]   min_mv
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [NUM_PART*SAD_W-1:0]   min_sad_q, min_sad_d;
  logic [NUM_PART*MV_W-1:0]    min_mv_q, min_mv_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic [SAD_W-1:0]            lane_sad;
  logic [SAD_W-1:0]            lane_min;
  logic                        lane_upd;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    min_sad_d = min_sad_q;
    min_mv_d  = min_mv_q;
    lane_sad  = '0;
    lane_min  = '0;
    lane_upd  = 1'b0;

    // start wins in every state, including an abort mid-window and a restart in DONE
    if (start) begin
      state_d   = SEARCH;
      cnt_d     = '0;
      min_sad_d = '1;
      min_mv_d  = '0;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        SEARCH: begin
          if (in_valid) begin
            cnt_d = cnt_q + CNT_W'(1);
            for (int i = 0; i < NUM_PART; i++) begin
              lane_sad = sad_in[i*SAD_W +: SAD_W];
              lane_min = min_sad_q[i*SAD_W +: SAD_W];
              lane_upd = (TIE_FIRST != 0) ? (lane_sad < lane_min) : (lane_sad <= lane_min);
              if (lane_upd) begin
                min_sad_d[i*SAD_W +: SAD_W] = lane_sad;
                min_mv_d[i*MV_W +: MV_W]    = mv_in;
              end
            end
            if (cnt_d == CNT_W'(NUM_CAND)) state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // status flags are registered copies of the next state
    busy_d = (state_d == SEARCH);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      min_sad_q <= '1;
      min_mv_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      min_sad_q <= min_sad_d;
      min_mv_q  <= min_mv_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign cand_cnt = cnt_q;
  assign min_sad  = min_sad_q;
  assign min_mv   = min_mv_q;

endmodule

// File: tb/tb_sad_min_tracker.sv
// Self-checking bench for sad_min_tracker: two lanes, four candidates, both tie policies side by side.
// Expected window results are queued when beats are driven and popped when done is seen.
module tb_sad_min_tracker;

  localparam int NUM_PART = 2;
  localparam int SAD_W    = 13;
  localparam int MV_W     = 12;
  localparam int NUM_CAND = 4;
  localparam int CNT_W    = $clog2(NUM_CAND + 1);
  localparam logic [NUM_PART*SAD_W-1:0] ONES = {13'h1FFF, 13'h1FFF};

  typedef struct packed {
    logic [NUM_PART*SAD_W-1:0] sad;
    logic [NUM_PART*MV_W-1:0]  mv;
    logic [NUM_PART*MV_W-1:0]  mv_tl;
    logic [CNT_W-1:0]          cnt;
  } exp_t;

  logic                      clk;
  logic                      rst;
  logic                      start;
  logic                      in_valid;
  logic [NUM_PART*SAD_W-1:0] sad_in;
  logic [MV_W-1:0]           mv_in;
  logic                      busy, busy_tl;
  logic                      done, done_tl;
  logic [CNT_W-1:0]          cand_cnt, cand_cnt_tl;
  logic [NUM_PART*SAD_W-1:0] min_sad, min_sad_tl;
  logic [NUM_PART*MV_W-1:0]  min_mv, min_mv_tl;

  exp_t sb_q[$];
  int   n_cmp;
  int   n_fail;
  int   done_cnt;

  sad_min_tracker #(
    .NUM_PART(NUM_PART), .SAD_W(SAD_W), .MV_W(MV_W), .NUM_CAND(NUM_CAND), .TIE_FIRST(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .sad_in(sad_in), .mv_in(mv_in),
    .busy(busy), .done(done), .cand_cnt(cand_cnt), .min_sad(min_sad), .min_mv(min_mv)
  );

  sad_min_tracker #(
    .NUM_PART(NUM_PART), .SAD_W(SAD_W), .MV_W(MV_W), .NUM_CAND(NUM_CAND), .TIE_FIRST(0)
  ) dut_tl (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .sad_in(sad_in), .mv_in(mv_in),
    .busy(busy_tl), .done(done_tl), .cand_cnt(cand_cnt_tl), .min_sad(min_sad_tl), .min_mv(min_mv_tl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Independent reference: plain minimum over the beat list under each tie rule.
  function automatic exp_t calc(input logic [3:0][12:0] s1, input logic [3:0][12:0] s0,
                                input logic [3:0][11:0] mv);
    exp_t e;
    logic [12:0] b1, b0, t1, t0;
    logic [11:0] m1, m0, n1, n0;
    b1 = '1; b0 = '1; t1 = '1; t0 = '1;
    m1 = '0; m0 = '0; n1 = '0; n0 = '0;
    for (int b = 0; b < 4; b++) begin
      if (s1[b] <  b1) begin b1 = s1[b]; m1 = mv[b]; end
      if (s0[b] <  b0) begin b0 = s0[b]; m0 = mv[b]; end
      if (s1[b] <= t1) begin t1 = s1[b]; n1 = mv[b]; end
      if (s0[b] <= t0) begin t0 = s0[b]; n0 = mv[b]; end
    end
    e.sad   = {b1, b0};
    e.mv    = {m1, m0};
    e.mv_tl = {n1, n0};
    e.cnt   = CNT_W'(4);
    return e;
  endfunction

  // One clock: inputs applied now, captured on the next rising edge, outputs sampled 1ns later.
  task automatic step(input logic st, input logic v, input logic [12:0] a1, input logic [12:0] a0,
                      input logic [11:0] m);
    start    = st;
    in_valid = v;
    sad_in   = {a1, a0};
    mv_in    = m;
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  // Packed beat arrays are indexed by beat number: element 0 is the first beat.
  task automatic drive_beats(input logic [3:0][12:0] s1, input logic [3:0][12:0] s0,
                             input logic [3:0][11:0] mv);
    sb_q.push_back(calc(s1, s0, mv));
    for (int b = 0; b < 4; b++) step(1'b0, 1'b1, s1[b], s0[b], mv[b]);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (cand_cnt !== '0) begin n_fail++; $display("[TB] FAIL reset_cnt: got %0d want 0", cand_cnt); end
    n_cmp++; if (min_sad !== ONES) begin n_fail++; $display("[TB] FAIL reset_min_sad: got %h want %h", min_sad, ONES); end
    n_cmp++; if (min_mv !== '0) begin n_fail++; $display("[TB] FAIL reset_min_mv: got %h want 0", min_mv); end
  endtask

  task automatic test_basic;
    exp_t e;
    step(1'b1, 1'b0, 13'd0, 13'd0, 12'h0);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_busy_rise: got %b want 1", busy); end
    n_cmp++; if (min_sad !== ONES) begin n_fail++; $display("[TB] FAIL basic_init_sad: got %h want %h", min_sad, ONES); end
    drive_beats({13'd2, 13'd0, 13'd3, 13'd1}, {13'd0, 13'd5, 13'd3, 13'd1},
                {12'h004, 12'h003, 12'h002, 12'h001});
    e = sb_q.pop_front();
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_done: got %b want 1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_busy_fall: got %b want 0", busy); end
    n_cmp++; if (min_sad !== e.sad) begin n_fail++; $display("[TB] FAIL basic_min_sad: got %h want %h", min_sad, e.sad); end
    n_cmp++; if (min_mv !== e.mv) begin n_fail++; $display("[TB] FAIL basic_min_mv: got %h want %h", min_mv, e.mv); end
    n_cmp++; if (min_mv !== 24'h003004) begin n_fail++; $display("[TB] FAIL basic_min_mv_const: got %h want 003004", min_mv); end
    n_cmp++; if (cand_cnt !== e.cnt) begin n_fail++; $display("[TB] FAIL basic_cnt: got %0d want %0d", cand_cnt, e.cnt); end
    step(1'b0, 1'b0, 13'd0, 13'd0, 12'h0);
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_ties;
    exp_t e;
    step(1'b1, 1'b0, 13'd0, 13'd0, 12'h0);
    drive_beats({4{13'd7}}, {4{13'd7}}, {12'h004, 12'h003, 12'h002, 12'h001});
    e = sb_q.pop_front();
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL ties_done: got %b want 1", done); end
    n_cmp++; if (min_mv !== e.mv) begin n_fail++; $display("[TB] FAIL ties_first_mv: got %h want %h", min_mv, e.mv); end
    n_cmp++; if (min_mv_tl !== e.mv_tl) begin n_fail++; $display("[TB] FAIL ties_last_mv: got %h want %h", min_mv_tl, e.mv_tl); end
    n_cmp++; if (min_mv_tl !== 24'h004004) begin n_fail++; $display("[TB] FAIL ties_last_mv_const: got %h want 004004", min_mv_tl); end
    n_cmp++; if (min_sad_tl !== {13'd7, 13'd7}) begin n_fail++; $display("[TB] FAIL ties_last_sad: got %h want 7|7", min_sad_tl); end
    step(1'b0, 1'b0, 13'd0, 13'd0, 12'h0);
  endtask

  task automatic test_gaps;
    exp_t e;
    sb_q.push_back(calc({13'd8, 13'd1, 13'd6, 13'd5}, {13'd9, 13'd3, 13'd2, 13'd4},
                        {12'h013, 12'h012, 12'h011, 12'h010}));
    step(1'b1, 1'b0, 13'd0, 13'd0, 12'h0);
    step(1'b0, 1'b1, 13'd5, 13'd4, 12'h010);
    step(1'b0, 1'b1, 13'd6, 13'd2, 12'h011);
    for (int g = 0; g < 3; g++) begin
      step(1'b0, 1'b0, 13'd0, 13'd0, 12'hFFF);
      n_cmp++; if (cand_cnt !== CNT_W'(2)) begin n_fail++; $display("[TB] FAIL gap_cnt_hold: got %0d want 2", cand_cnt); end
      n_cmp++; if (min_sad !== {13'd5, 13'd2}) begin n_fail++; $display("[TB] FAIL gap_sad_hold: got %h want 5|2", min_sad); end
    end
    step(1'b0, 1'b1, 13'd1, 13'd3, 12'h012);
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL gap_early_done: got %b want 0", done); end
    step(1'b0, 1'b1, 13'd8, 13'd9, 12'h013);
    e = sb_q.pop_front();
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL gap_done: got %b want 1", done); end
    n_cmp++; if (min_sad !== e.sad) begin n_fail++; $display("[TB] FAIL gap_min_sad: got %h want %h", min_sad, e.sad); end
    n_cmp++; if (min_mv !== e.mv) begin n_fail++; $display("[TB] FAIL gap_min_mv: got %h want %h", min_mv, e.mv); end
    for (int c = 0; c < 10; c++) begin
      step(1'b0, (c % 2) == 0, 13'd0, 13'd0, 12'hABC);
      n_cmp++;
      if (min_sad !== e.sad || min_mv !== e.mv || cand_cnt !== e.cnt || busy !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL idle_hold[%0d]: got sad %h mv %h cnt %0d busy %b want sad %h mv %h cnt %0d busy 0",
                 c, min_sad, min_mv, cand_cnt, busy, e.sad, e.mv, e.cnt);
      end
    end
  endtask

  task automatic test_abort;
    exp_t e;
    int   d0;
    d0 = done_cnt;
    step(1'b1, 1'b0, 13'd0, 13'd0, 12'h0);
    step(1'b0, 1'b1, 13'd1, 13'd1, 12'h001);
    step(1'b0, 1'b1, 13'd1, 13'd1, 12'h002);
    step(1'b1, 1'b1, 13'd0, 13'd0, 12'h03F);
    n_cmp++; if (cand_cnt !== '0) begin n_fail++; $display("[TB] FAIL abort_cnt: got %0d want 0", cand_cnt); end
    n_cmp++; if (min_sad !== ONES) begin n_fail++; $display("[TB] FAIL abort_reinit_sad: got %h want %h", min_sad, ONES); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_busy: got %b want 1", busy); end
    drive_beats({4{13'd9}}, {4{13'd9}}, {12'h008, 12'h007, 12'h006, 12'h005});
    e = sb_q.pop_front();
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_done: got %b want 1", done); end
    n_cmp++; if (min_sad !== e.sad) begin n_fail++; $display("[TB] FAIL abort_min_sad: got %h want %h", min_sad, e.sad); end
    n_cmp++; if (min_mv !== e.mv) begin n_fail++; $display("[TB] FAIL abort_min_mv: got %h want %h", min_mv, e.mv); end
    step(1'b0, 1'b0, 13'd0, 13'd0, 12'h0);
    n_cmp++; if (done_cnt - d0 !== 1) begin n_fail++; $display("[TB] FAIL abort_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_mid_reset;
    int d0;
    d0 = done_cnt;
    step(1'b1, 1'b0, 13'd0, 13'd0, 12'h0);
    step(1'b0, 1'b1, 13'd1, 13'd1, 12'h001);
    step(1'b0, 1'b1, 13'd2, 13'd2, 12'h002);
    rst = 1'b1;
    step(1'b0, 1'b1, 13'd0, 13'd0, 12'h003);
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (min_sad !== ONES) begin n_fail++; $display("[TB] FAIL rst_min_sad: got %h want %h", min_sad, ONES); end
    n_cmp++; if (min_mv !== '0) begin n_fail++; $display("[TB] FAIL rst_min_mv: got %h want 0", min_mv); end
    n_cmp++; if (cand_cnt !== '0) begin n_fail++; $display("[TB] FAIL rst_cnt: got %0d want 0", cand_cnt); end
    for (int c = 0; c < 6; c++) step(1'b0, 1'b1, 13'd0, 13'd0, 12'h03F);
    n_cmp++; if (cand_cnt !== '0) begin n_fail++; $display("[TB] FAIL rst_ignore_cnt: got %0d want 0", cand_cnt); end
    n_cmp++; if (min_sad !== ONES) begin n_fail++; $display("[TB] FAIL rst_ignore_sad: got %h want %h", min_sad, ONES); end
    n_cmp++; if (done_cnt !== d0) begin n_fail++; $display("[TB] FAIL rst_no_done: got %0d pulses want 0", done_cnt - d0); end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    step(1'b1, 1'b0, 13'd0, 13'd0, 12'h0);
    drive_beats({4{13'd0}}, {4{13'd0}}, {12'h014, 12'h013, 12'h012, 12'h011});
    e = sb_q.pop_front();
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_done_a: got %b want 1", done); end
    n_cmp++; if (min_mv !== e.mv) begin n_fail++; $display("[TB] FAIL b2b_mv_a: got %h want %h", min_mv, e.mv); end
    step(1'b1, 1'b0, 13'd0, 13'd0, 12'h0);
    n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_restart: got busy %b done %b want 1 0", busy, done); end
    n_cmp++; if (min_sad !== ONES) begin n_fail++; $display("[TB] FAIL b2b_reinit_sad: got %h want %h", min_sad, ONES); end
    drive_beats({4{13'h1FFF}}, {13'd6, 13'd4, 13'd4, 13'd10}, {12'h024, 12'h023, 12'h022, 12'h021});
    e = sb_q.pop_front();
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_done_b: got %b want 1", done); end
    n_cmp++; if (min_sad !== e.sad) begin n_fail++; $display("[TB] FAIL b2b_sad_b: got %h want %h", min_sad, e.sad); end
    n_cmp++; if (min_mv !== e.mv) begin n_fail++; $display("[TB] FAIL b2b_mv_b: got %h want %h", min_mv, e.mv); end
    n_cmp++; if (min_mv_tl !== e.mv_tl) begin n_fail++; $display("[TB] FAIL b2b_mv_tl_b: got %h want %h", min_mv_tl, e.mv_tl); end
    n_cmp++; if (min_sad_tl !== e.sad) begin n_fail++; $display("[TB] FAIL b2b_sad_tl_b: got %h want %h", min_sad_tl, e.sad); end
    step(1'b0, 1'b0, 13'd0, 13'd0, 12'h0);
  endtask

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    done_cnt = 0;
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    sad_in   = '0;
    mv_in    = '0;
    test_reset;
    test_basic;
    test_ties;
    test_gaps;
    test_abort;
    test_mid_reset;
    test_back_to_back;
    n_cmp++; if (sb_q.size() != 0) begin n_fail++; $display("[TB] FAIL scoreboard_drain: got %0d left want 0", sb_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sad_min_tracker.md
# sad_min_tracker

Parametrised per-partition minimum-SAD tracker for the integer motion estimation datapath. It accepts one packed vector of SADs, one per partition, per candidate motion vector over a search window. It keeps the running minimum SAD and its winning MV for every partition independently, and signals completion after a fixed number of candidates. It sits between the SAD accumulation tree and the MV decision/output stage, and replaces the fixed-shape comparator with one instance per partition shape (4x8, 8x4, 8x8, 8x16, 16x8, 16x16).

## Interface

Parameters:
- NUM_PART, 32, number of partitions (lanes) in the packed SAD bus
- SAD_W, 13, width of one SAD value in bits (unsigned)
- MV_W, 12, width of one packed candidate MV ({mvx, mvy}, opaque to this block)
- NUM_CAND, 64, candidates per search window, >= 1
- TIE_FIRST, 1, 1 = earliest candidate wins on equal SAD; 0 = latest candidate wins

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset; one clock, synchronous and active-high
- start  in  1  single-cycle pulse; begins a new search window
- in_valid  in  1  sad_in/mv_in carry one candidate this cycle
- sad_in  in  NUM_PART*SAD_W  packed SADs; lane i at [i*SAD_W +: SAD_W]
- mv_in  in  MV_W  MV of the current candidate, shared by all lanes
- busy  out  1  high in SEARCH state
- done  out  1  one-cycle pulse when the window completes
- cand_cnt  out  clog2(NUM_CAND+1)  candidates accepted in the current window
- min_sad  out  NUM_PART*SAD_W  running/final minimum per lane, same packing as sad_in
- min_mv  out  NUM_PART*MV_W  MV of each lane's minimum; lane i at [i*MV_W +: MV_W]

## Operation

- FSM states: IDLE, SEARCH, DONE.
- IDLE:
  - start -> SEARCH.
  - On that edge: all min_sad lanes load all-ones, min_mv loads 0, cand_cnt loads 0.
  - in_valid is ignored.
- SEARCH:
  - Each in_valid beat increments cand_cnt.
  - For each lane i, independently:
    - TIE_FIRST=1: update when sad_in[i] < min_sad[i] (strict).
    - TIE_FIRST=0: update when sad_in[i] <= min_sad[i].
    - An update loads min_sad[i] <= sad_in[i] and min_mv[i] <= mv_in.
  - The first beat always updates every lane, because it is compared against all-ones. The exception is TIE_FIRST=1 with an all-ones SAD: the lane's min_sad stays all-ones and min_mv stays 0.
  - The beat that makes cand_cnt == NUM_CAND -> DONE.
  - start in SEARCH aborts the window and reinitialises exactly as from IDLE, staying in SEARCH. A coincident in_valid is discarded.
- DONE:
  - Lasts one cycle, with done=1; then -> IDLE.
  - in_valid is ignored.
  - start in DONE is honoured: -> SEARCH with reinit, and done is still 1 that cycle.
- Outputs hold their last values in IDLE until the next start, so the consumer may sample them at any time after done.
- Compare is an unsigned SAD_W-bit magnitude compare. No saturation or arithmetic is performed; the block only selects.
- rst: state <- IDLE, busy=0, done=0, cand_cnt=0, min_sad all-ones, min_mv=0. A mid-window reset discards the window and produces no done.

## Timing

- All outputs are registered. No combinational path from any input to any output.
- A beat at edge N is visible on min_sad/min_mv/cand_cnt after edge N.
- The final beat at edge N gives done=1 and busy=0 during cycle N+1, with final minima already valid. Latency from last beat to done is 1 cycle.
- busy rises the cycle after start and falls together with the rise of done.
- Minimum start-to-start period for back-to-back windows: NUM_CAND+1 cycles (start, NUM_CAND beats, start coincident with DONE).
- in_valid gaps in SEARCH are allowed. They stall the counter and leave the minima unchanged.

## Test plan

- Settings: NUM_PART=2, SAD_W=13, NUM_CAND=4, TIE_FIRST=1 unless stated. Notation: lane1|lane0.
- Basic min: start; beats (sad 1|1, mv 0x001), (3|3, 0x002), (0|5, 0x003), (2|0, 0x004).
  - Required: done one cycle after beat 4, min_sad=0|0, min_mv=0x003|0x004, cand_cnt=4.
- Ties:
  - TIE_FIRST=1, beats all 7|7 with mv 1..4 -> min_mv=0x001|0x001.
  - TIE_FIRST=0, same beats -> min_mv=0x004|0x004.
- Gaps and hold: beats with in_valid low for 3 cycles between beats 2 and 3.
  - Required: done exactly 1 cycle after beat 4; cand_cnt holds 2 during the gap.
  - Outputs unchanged for 10 IDLE cycles afterwards.
- Abort: start, 2 beats (sad 1|1), start again with in_valid high, then 4 beats of 9|9.
  - Required: min_sad=9|9, only one done pulse; the beat coincident with start is not counted.
- Reset mid-window: rst high after beat 2 for one cycle.
  - Required: no done, min_sad=0x1FFF|0x1FFF, min_mv=0, busy=0.
  - Subsequent in_valid without start is ignored.
- Back-to-back: start asserted in the DONE cycle.
  - Required: done=1 and reinit on the same edge; second window's results are independent of the first.
